// File: rtl/ceespu_lsu_pkg.sv
// Shared ceespu definitions: access-size encodings, execute lane codes and
// the load/store unit FSM states.
package ceespu_lsu_pkg;

    // Access size encodings carried on I_size
    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    // Lane codes handed to execute on selMem[2:0]. Half and byte codes are
    // bases; the low address bits are OR-ed in to pick the lane.
    localparam logic [2:0] LANE_WORD = 3'b000;
    localparam logic [2:0] LANE_HALF = 3'b010;
    localparam logic [2:0] LANE_BYTE = 3'b100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/ceespu_lsu_lane.sv
// Combinational lane steering: turns access size and low address bits into
// byte enables, replicated store data, execute lane code and a legality flag.
module ceespu_lsu_lane
    import ceespu_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [2:0]  lane,
    output logic        legal
);

    // Decode size/alignment; size 3 falls through to the illegal defaults
    always_comb begin
        be    = 4'b0000;
        wdata = 32'h0;
        lane  = LANE_WORD;
        legal = 1'b0;
        case (size)
            SZ_WORD: begin
                be    = 4'b1111;
                wdata = data;
                lane  = LANE_WORD;
                legal = (addr_lo == 2'b00);
            end
            SZ_HALF: begin
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{data[15:0]}};
                lane  = LANE_HALF | {2'b00, addr_lo[1]};
                legal = ~addr_lo[0];
            end
            SZ_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{data[7:0]}};
                lane  = LANE_BYTE | {1'b0, addr_lo};
                legal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ceespu_lsu.sv
// ceespu load/store unit: single-outstanding req/ack data bus master that
// hands the raw read word plus lane/sign selector to execute.
//
// Handshake: an op is taken when I_valid is high in IDLE (legal ops only);
// upstream must hold its op while O_busy is high. On the bus, O_bus_req stays
// high with all bus fields frozen until the cycle I_bus_ack is sampled high,
// which completes the transfer on that clock edge; ack outside REQ is ignored.
module ceespu_lsu
    import ceespu_lsu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_valid,
    input  logic              I_write,
    input  logic [1:0]        I_size,
    input  logic              I_signed,
    input  logic [31:0]       I_addr,
    input  logic [31:0]       I_dataS,
    output logic              O_busy,
    output logic [31:0]       O_memA,
    output logic [3:0]        O_selMem,
    output logic              O_rvalid,
    output logic              O_misalign,
    output logic              O_fault,
    output logic              O_bus_req,
    output logic              O_bus_we,
    output logic [ADDR_W-3:0] O_bus_addr,
    output logic [3:0]        O_bus_be,
    output logic [31:0]       O_bus_wdata,
    input  logic              I_bus_ack,
    input  logic [31:0]       I_bus_rdata,
    output logic              O_dbg_state
);

    // A zero TIMEOUT still gets a 1-bit counter so widths stay legal
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        ln_be;
    logic [31:0]       ln_wdata;
    logic [2:0]        ln_lane;
    logic              ln_legal;
    logic              accept;
    logic              reject;
    logic              timeout_hit;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^I_addr[31:ADDR_W];

    ceespu_lsu_lane u_lane (
        .size    (I_size),
        .addr_lo (I_addr[1:0]),
        .data    (I_dataS),
        .be      (ln_be),
        .wdata   (ln_wdata),
        .lane    (ln_lane),
        .legal   (ln_legal)
    );

    assign accept      = (state == ST_IDLE) && I_valid && ln_legal;
    assign reject      = (state == ST_IDLE) && I_valid && !ln_legal;
    // Last allowed wait cycle: req has then been high for TIMEOUT cycles
    assign timeout_hit = (TIMEOUT != 0) && (state == ST_REQ) && !I_bus_ack &&
                         (cnt == CNT_W'(TIMEOUT - 1));

    assign O_busy      = accept || ((state == ST_REQ) && !I_bus_ack);
    assign O_bus_req   = (state == ST_REQ);
    assign O_dbg_state = state;

    // FSM state register; async reset drops req immediately
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: accept enters REQ, ack or timeout returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_REQ;
            ST_REQ:  if (I_bus_ack || timeout_hit) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Wait-cycle counter: counts REQ cycles, cleared in IDLE
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst)                cnt <= '0;
        else if (state == ST_REQ)  cnt <= cnt + 1'b1;
        else                       cnt <= '0;
    end

    // Bus fields, selector, read word and the one-cycle status pulses
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            O_bus_we    <= 1'b0;
            O_bus_addr  <= '0;
            O_bus_be    <= 4'b0000;
            O_bus_wdata <= 32'h0;
            O_selMem    <= 4'b0000;
            O_memA      <= 32'h0;
            O_rvalid    <= 1'b0;
            O_misalign  <= 1'b0;
            O_fault     <= 1'b0;
        end else begin
            O_rvalid   <= 1'b0;
            O_misalign <= reject;
            O_fault    <= timeout_hit;
            if (accept) begin
                O_bus_we    <= I_write;
                O_bus_addr  <= I_addr[ADDR_W-1:2];
                O_bus_be    <= ln_be;
                O_bus_wdata <= ln_wdata;
                O_selMem    <= {I_signed, ln_lane};
            end
            if ((state == ST_REQ) && I_bus_ack && !O_bus_we) begin
                O_memA   <= I_bus_rdata;
                O_rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ceespu_lsu.sv
// Bench for ceespu_lsu: directed scenarios followed by random ops, checked
// against an arithmetic reference of the access rules.
module tb_ceespu_lsu;

    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 4;

    logic        clk;
    logic        rst_n;
    logic        i_valid, i_write, i_signed;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_data_s;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        o_busy, o_rvalid, o_misalign, o_fault;
    logic [31:0] o_mem_a;
    logic [3:0]  o_sel_mem;
    logic        bus_req, bus_we;
    logic [ADDR_W-3:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        dbg_state;

    ceespu_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .I_clk       (clk),
        .I_rst       (rst_n),
        .I_valid     (i_valid),
        .I_write     (i_write),
        .I_size      (i_size),
        .I_signed    (i_signed),
        .I_addr      (i_addr),
        .I_dataS     (i_data_s),
        .O_busy      (o_busy),
        .O_memA      (o_mem_a),
        .O_selMem    (o_sel_mem),
        .O_rvalid    (o_rvalid),
        .O_misalign  (o_misalign),
        .O_fault     (o_fault),
        .O_bus_req   (bus_req),
        .O_bus_we    (bus_we),
        .O_bus_addr  (bus_addr),
        .O_bus_be    (bus_be),
        .O_bus_wdata (bus_wdata),
        .I_bus_ack   (bus_ack),
        .I_bus_rdata (bus_rdata),
        .O_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem_a_exp = 32'h0;
    logic [3:0]  sel_exp   = 4'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned ref_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 4;
            2'd1:    return 2;
            2'd2:    return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [1:0] sz, input logic [31:0] a);
        int unsigned n = ref_bytes(sz);
        if (n == 0) return 1'b0;
        return (a % n) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
        int unsigned n = ref_bytes(sz);
        int unsigned mask = (1 << n) - 1;
        return 4'(mask << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd2) return (d % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [2:0] ref_lane(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd2) return 3'(4 + a % 4);
        if (sz == 2'd1) return 3'(2 + (a / 2) % 2);
        return 3'd0;
    endfunction

    // ---------------- driver ----------------
    // Presents one op at a negedge, services the bus, and checks the whole
    // transaction. waits = ack delay in REQ cycles; no_ack lets it time out.
    task automatic run_op(input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] d,
                          input int waits, input bit no_ack, input logic [31:0] rd);
        bit legal = ref_legal(sz, a);
        int req_cycles = 0;
        bit done = 0;
        @(negedge clk);
        chk("pulse_rvalid_idle", {31'h0, o_rvalid}, 32'h0);
        chk("pulse_misalign_idle", {31'h0, o_misalign}, 32'h0);
        chk("pulse_fault_idle", {31'h0, o_fault}, 32'h0);
        i_valid = 1'b1; i_write = w; i_size = sz; i_signed = sg;
        i_addr = a; i_data_s = d;
        #1 chk("busy_accept", {31'h0, o_busy}, {31'h0, legal});
        @(negedge clk);
        i_valid = 1'b0;
        if (!legal) begin
            chk("misalign_pulse", {31'h0, o_misalign}, 32'h1);
            chk("misalign_noreq", {31'h0, bus_req}, 32'h0);
            chk("misalign_busy", {31'h0, o_busy}, 32'h0);
            chk("misalign_sel_hold", {28'h0, o_sel_mem}, {28'h0, sel_exp});
            return;
        end
        sel_exp = {sg, ref_lane(sz, a)};
        if (!w && !no_ack) exp_q.push_back(rd);
        for (int k = 0; k < 64; k++) begin
            if (!bus_req) begin done = 1; break; end
            req_cycles++;
            chk("bus_addr", 32'(bus_addr), 32'(a[ADDR_W-1:2]));
            chk("bus_be", {28'h0, bus_be}, {28'h0, ref_be(sz, a)});
            chk("bus_we", {31'h0, bus_we}, {31'h0, w});
            if (w) chk("bus_wdata", bus_wdata, ref_wdata(sz, d));
            chk("sel_mem", {28'h0, o_sel_mem}, {28'h0, sel_exp});
            if (!no_ack && k == waits) begin
                bus_ack = 1'b1; bus_rdata = rd;
                #1 chk("busy_ack_cycle", {31'h0, o_busy}, 32'h0);
                @(negedge clk);
                bus_ack = 1'b0; bus_rdata = $urandom;
                done = 1;
                break;
            end
            #1 chk("busy_wait", {31'h0, o_busy}, 32'h1);
            @(negedge clk);
        end
        if (!done) chk("req_bounded", 32'h1, 32'h0);
        chk("req_dropped", {31'h0, bus_req}, 32'h0);
        chk("req_cycles", 32'(req_cycles), no_ack ? 32'(TIMEOUT) : 32'(waits + 1));
        chk("fault", {31'h0, o_fault}, {31'h0, no_ack});
        chk("rvalid", {31'h0, o_rvalid}, {31'h0, (!w && !no_ack)});
        if (o_rvalid && exp_q.size() != 0) mem_a_exp = exp_q.pop_front();
        chk("mem_a", o_mem_a, mem_a_exp);
        chk("sel_hold", {28'h0, o_sel_mem}, {28'h0, sel_exp});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'h0, bus_req}, 32'h0);
        chk({tag, "_we"}, {31'h0, bus_we}, 32'h0);
        chk({tag, "_be"}, {28'h0, bus_be}, 32'h0);
        chk({tag, "_addr"}, 32'(bus_addr), 32'h0);
        chk({tag, "_wdata"}, bus_wdata, 32'h0);
        chk({tag, "_mem_a"}, o_mem_a, 32'h0);
        chk({tag, "_sel"}, {28'h0, o_sel_mem}, 32'h0);
        chk({tag, "_pulses"}, {29'h0, o_rvalid, o_misalign, o_fault}, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] held;
        rst_n = 1'b0; i_valid = 1'b0; i_write = 1'b0; i_size = 2'd0;
        i_signed = 1'b0; i_addr = 32'h0; i_data_s = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Directed scenarios
        run_op(0, 2'd0, 0, 32'h0000_0010, 32'h0, 3, 0, 32'hCAFE_BABE);
        run_op(1, 2'd2, 1, 32'h0000_0013, 32'h0000_00A5, 0, 0, 32'h1234_5678);
        run_op(0, 2'd1, 0, 32'h0000_0002, 32'h0, 1, 0, 32'h8001_7FFE);
        run_op(0, 2'd0, 0, 32'h0000_0006, 32'h0, 0, 0, 32'h0);
        run_op(0, 2'd1, 1, 32'h0000_0001, 32'h0, 0, 0, 32'h0);
        run_op(1, 2'd3, 0, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
        run_op(0, 2'd0, 1, 32'h0000_0020, 32'h0, 0, 1, 32'h0);

        // Late ack after the timeout must be ignored
        held = o_mem_a;
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("late_ack_rvalid", {31'h0, o_rvalid}, 32'h0);
        chk("late_ack_mem_a", o_mem_a, held);

        // Reset while waiting for ack
        @(negedge clk);
        i_valid = 1'b1; i_write = 1'b0; i_size = 2'd0; i_addr = 32'h0000_0040;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        chk("pre_reset_req", {31'h0, bus_req}, 32'h1);
        rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        bus_ack = 1'b0;
        chk("post_reset_rvalid", {31'h0, o_rvalid}, 32'h0);
        chk("post_reset_mem_a", o_mem_a, 32'h0);
        mem_a_exp = 32'h0; sel_exp = 4'h0;

        // Random ops
        for (int n = 0; n < 60; n++) begin
            run_op($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
                   $urandom, $urandom, $urandom_range(0, TIMEOUT - 1),
                   ($urandom_range(0, 7) == 0), $urandom);
        end

        @(negedge clk);
        chk("final_pulses", {29'h0, o_rvalid, o_misalign, o_fault}, 32'h0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ceespu_lsu.md
# ceespu_lsu

Load/store unit for the ceespu core. It sits directly upstream of the execute stage's load-data path. It accepts one memory operation per issue and drives a single-outstanding req/ack data bus with word address, byte enables and lane-replicated store data. It hands the raw read word and the lane/sign selector to execute, which does the final extract and sign-extension. It stalls the pipeline while a bus transaction is open and flags misaligned or timed-out accesses.

## Interface
- ADDR_W, 16: byte-address width of the data bus space.
- TIMEOUT, 255: max cycles waiting for ack; 0 disables the timeout.

- I_clk  in  1  core clock.
- I_rst  in  1  reset, asynchronous, active-low.
- I_valid  in  1  memory op presented this cycle.
- I_write  in  1  1 = store, 0 = load.
- I_size  in  2  0 word, 1 half, 2 byte, 3 illegal.
- I_signed  in  1  sign-extend the load result (forwarded as selMem[3]).
- I_addr  in  32  effective byte address; only [ADDR_W-1:0] used.
- I_dataS  in  32  store data, right-aligned.
- O_busy  out  1  pipeline stall request.
- O_memA  out  32  registered raw read word.
- O_selMem  out  4  {signed, lane code} for execute.
- O_rvalid  out  1  1-cycle pulse, O_memA updated.
- O_misalign  out  1  1-cycle pulse, access rejected.
- O_fault  out  1  1-cycle pulse, bus timeout.
- O_bus_req  out  1  bus request.
- O_bus_we  out  1  write strobe.
- O_bus_addr  out  ADDR_W-2  word address.
- O_bus_be  out  4  byte enables.
- O_bus_wdata  out  32  store data.
- I_bus_ack  in  1  transfer complete.
- I_bus_rdata  in  32  read data, valid with ack.

## Operation
- FSM has 2 states: IDLE and REQ.
- Legal op:
  - Word needs addr[1:0]=0.
  - Half needs addr[0]=0.
  - Byte is always legal.
  - Size 3 is illegal.
- Accept: in IDLE with I_valid and a legal op, latch the bus fields and O_selMem, then go to REQ.
- Illegal op: stays in IDLE, no bus activity. O_misalign pulses the next cycle.
- Lane code (O_selMem[2:0]):
  - word: 000.
  - half: {2'b01, addr[1]}.
  - byte: {1'b1, addr[1:0]}.
  - O_selMem[3] = I_signed.
  - O_selMem holds until the next accepted op.
- Byte enables:
  - word: 1111.
  - half: addr[1] ? 1100 : 0011.
  - byte: 0001 << addr[1:0].
  - Byte lane 0 is bits [7:0] (little-endian).
- Store data: word is passed through; half is {2{d[15:0]}}; byte is {4{d[7:0]}}.
- Bus fields are held constant while O_bus_req=1.
- REQ:
  - O_bus_req=1. A cycle counter starts at 0.
  - On I_bus_ack: go to IDLE. For a load, O_memA<=I_bus_rdata and O_rvalid pulses the next cycle. A store updates nothing.
  - If the counter reaches TIMEOUT (TIMEOUT≠0) with no ack: go to IDLE, drop req, O_fault pulses, O_memA unchanged.
- Ack while not in REQ is ignored. I_valid while in REQ is ignored; upstream holds under O_busy.
- O_busy = (IDLE & I_valid & legal) | (REQ & !I_bus_ack). It is combinational and drops in the ack cycle, so the pipeline advances on the same edge that captures the data.

## Timing
- Reset (async, I_rst low) forces:
  - state = IDLE, counter = 0.
  - O_bus_req, O_bus_we, O_bus_be, O_rvalid, O_misalign, O_fault = 0.
  - O_memA, O_bus_addr, O_bus_wdata = 0; O_selMem = 0.
  - Reset mid-transaction drops req immediately; a late ack is ignored.
- Cycle numbering:
  - Cycle 0: accept.
  - Cycle 1: O_bus_req high earliest.
  - With ack in cycle 1: O_memA and O_rvalid are valid in cycle 2.
  - Minimum load latency is 2 cycles; O_busy is high in cycle 0 only.
- Zero-wait bus gives 1 op per 2 cycles. Back-to-back accepts are impossible because REQ is always entered.
- Timeout: with no ack, req is high for exactly TIMEOUT cycles. O_fault is high in the first IDLE cycle after that.
- O_misalign and O_fault never overlap with O_bus_req rising.

## Structure
- Shared ceespu package holds:
  - size encodings (SZ_WORD/SZ_HALF/SZ_BYTE).
  - selMem lane-code constants (also used by execute).
  - the FSM state enum.
- Natural sub-module: ceespu_lsu_lane, combinational size+addr → be, wdata, lane code, legal. It is reusable by a future store buffer.
- Timeout counter width: $clog2(TIMEOUT+1).

## Test plan
- Word load at addr 0x0010, ack after 3 wait cycles, rdata 0xCAFEBABE:
  - O_bus_addr=0x004, be=1111, req high for 4 cycles.
  - Then O_memA=0xCAFEBABE, O_selMem=0000, O_rvalid 1 pulse.
- Signed byte store, I_dataS=0x000000A5, addr 0x0013, immediate ack:
  - be=1000, wdata=0xA5A5A5A5, we=1.
  - O_selMem=1111, O_rvalid stays 0.
- Halfword load at addr 0x0002 with I_signed=0: be=1100, O_selMem=0011.
- Misaligned ops (word at 0x0006, half at 0x0001, size 3):
  - no req, O_misalign pulses once each, O_busy never high past the accept cycle.
- TIMEOUT=4, no ack:
  - req high exactly 4 cycles, then O_fault pulse, O_memA unchanged.
  - A later ack is ignored.
- I_rst low 2 cycles into a REQ wait:
  - req drops asynchronously and all outputs go to reset values.
  - An ack after reset release produces no O_rvalid.
